rr_priority_finder: RTL

Parametrised round-robin successor to the combinational priority finder. Each cycle it reports up to GRANT_NUM set bits of a request vector. The scan starts from an internal rotating pointer, in ascending or descending order, and wraps modulo WIDTH. The pointer advances past the last granted position whenever the consumer accepts, which gives fair, starvation-free selection for issue/wakeup/free-list style arbitration in the core.

---
 rtl/rr_priority_finder.sv | 86 ++++++++
 1 files changed

// File: rtl/rr_priority_finder.sv
// Round-robin priority finder.
// Reports up to GRANT_NUM set bits of data_in, scanning from a rotating
// pointer in ascending or descending order with modulo-WIDTH wrap. The
// pointer moves past the last granted position whenever the consumer accepts.
// All outputs are combinational from data_in and the pointer.
module rr_priority_finder #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned GRANT_NUM      = 2,
   parameter bit          FIRST_PRIORITY = 1'b1
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [WIDTH-1:0]                          data_in,
   input  logic                                      accept,
   input  logic                                      flush,
   output logic [GRANT_NUM-1:0][$clog2(WIDTH)-1:0]   index,
   output logic [GRANT_NUM-1:0]                      index_valid,
   output logic [WIDTH-1:0]                          grant_mask
);

   localparam int unsigned IdxW = $clog2(WIDTH);
   localparam int unsigned CntW = $clog2(GRANT_NUM + 1);

   // Ascending scans start at 0, descending scans start at the top position.
   localparam logic [IdxW-1:0] PtrRst   = FIRST_PRIORITY ? '0 : IdxW'(WIDTH - 1);
   localparam logic [IdxW-1:0] PtrMax   = IdxW'(WIDTH - 1);
   localparam logic [IdxW:0]   WidthExt = (IdxW + 1)'(WIDTH);

   logic [IdxW-1:0] ptr_q;
   logic [IdxW-1:0] ptr_d;
   logic [IdxW-1:0] last_pos;
   logic [IdxW:0]   pos;
   logic [CntW-1:0] cnt;

   // Walk all WIDTH positions in scan order and collect the first GRANT_NUM set bits.
   always_comb begin
      index       = '0;
      index_valid = '0;
      grant_mask  = '0;
      last_pos    = '0;
      cnt         = '0;
      pos         = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         // One extra bit holds ptr+offset < 2*WIDTH; a single subtract wraps it.
         if (FIRST_PRIORITY) begin
            pos = {1'b0, ptr_q} + (IdxW + 1)'(i);
         end else begin
            pos = {1'b0, ptr_q} + (IdxW + 1)'(WIDTH - i);
         end
         if (pos >= WidthExt) begin
            pos = pos - WidthExt;
         end
         if (data_in[pos[IdxW-1:0]] && (cnt < CntW'(GRANT_NUM))) begin
            index[cnt]                  = pos[IdxW-1:0];
            index_valid[cnt]            = 1'b1;
            grant_mask[pos[IdxW-1:0]]   = 1'b1;
            last_pos                    = pos[IdxW-1:0];
            cnt                         = cnt + CntW'(1);
         end
      end
   end

   // Next pointer: flush wins over accept; accept without any grant holds.
   always_comb begin
      ptr_d = ptr_q;
      if (flush) begin
         ptr_d = PtrRst;
      end else if (accept && index_valid[0]) begin
         if (FIRST_PRIORITY) begin
            ptr_d = (last_pos == PtrMax) ? '0 : last_pos + IdxW'(1);
         end else begin
            ptr_d = (last_pos == '0) ? PtrMax : last_pos - IdxW'(1);
         end
      end
   end

   // Pointer register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= PtrRst;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
